// File: rtl/output_select_ctrl_pkg.sv
// Shared types and defaults for the output select controller and its bus-facing helpers.
package output_select_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ARM    = 2'd1,
      ACTIVE      = 2'd2,
      WAIT_DISARM = 2'd3
   } state_t;

   localparam int unsigned DEF_WIDTH       = 4;
   localparam int unsigned DEF_IDLE_CYCLES = 16;
   localparam int unsigned DEF_HOLD_WIDTH  = 16;

   // Counter width able to hold values 0..max inclusive.
   function automatic int unsigned cnt_width(input int unsigned max);
      return (max < 2) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/output_select_ctrl_if.sv
// Request/control bundle between command logic (master) and the select controller (slave).
interface output_select_ctrl_if #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned HOLD_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic [WIDTH-1:0]      req_mask;
   logic [HOLD_WIDTH-1:0] req_hold;
   logic                  release_req;
   logic                  bus_idle;
   logic [WIDTH-1:0]      select_line;
   logic                  busy;
   logic                  done;

   modport master (
      output req_valid, req_mask, req_hold, release_req, bus_idle,
      input  req_ready, select_line, busy, done
   );

   modport slave (
      input  req_valid, req_mask, req_hold, release_req, bus_idle,
      output req_ready, select_line, busy, done
   );
endinterface

// File: rtl/output_select_ctrl_bus_idle_timer.sv
// Qualifies the bus as quiet once bus_idle has been seen for IDLE_CYCLES consecutive cycles.
module bus_idle_timer
   import output_select_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 16
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic bus_idle,
   output logic qual
);
   localparam int unsigned CW = cnt_width(IDLE_CYCLES);

   logic [CW-1:0] idle_cnt;

   always_ff @(posedge sys_clk) begin
      if (rst || !bus_idle)
         idle_cnt <= '0;
      else if (idle_cnt != CW'(IDLE_CYCLES))
         idle_cnt <= idle_cnt + CW'(1);
   end

   // The live bus_idle term lets a drop on the would-be switch cycle veto the change.
   assign qual = (idle_cnt == CW'(IDLE_CYCLES)) && bus_idle;

endmodule

// File: rtl/output_select_ctrl.sv
// Sequences the output-mux select_line: applies an injection mask and later reverts it,
// switching only while the target bus has been idle long enough.
module output_select_ctrl
   import output_select_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
   parameter int unsigned HOLD_WIDTH  = DEF_HOLD_WIDTH
) (
   input logic                 sys_clk,
   input logic                 rst,
   output_select_ctrl_if.slave bus
);
   state_t                state;
   logic [WIDTH-1:0]      mask_q;
   logic [HOLD_WIDTH-1:0] hold_q;
   logic [HOLD_WIDTH-1:0] hold_cnt;
   logic [WIDTH-1:0]      select_q;
   logic                  ready_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  qual;

   bus_idle_timer #(.IDLE_CYCLES(IDLE_CYCLES)) u_idle_timer (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .bus_idle (bus.bus_idle),
      .qual     (qual)
   );

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state    <= IDLE;
         mask_q   <= '0;
         hold_q   <= '0;
         hold_cnt <= '0;
         select_q <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == ACTIVE && hold_cnt != '0)
            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
         unique case (state)
            IDLE: begin
               if (bus.req_valid && ready_q) begin
                  mask_q  <= bus.req_mask;
                  hold_q  <= bus.req_hold;
                  state   <= WAIT_ARM;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            WAIT_ARM: begin
               if (bus.release_req) begin
                  state   <= IDLE;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else if (qual) begin
                  select_q <= mask_q;
                  hold_cnt <= hold_q;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               // hold_cnt only sits at zero for an unbounded hold, so release is honoured only then.
               if (hold_cnt == HOLD_WIDTH'(1) || (hold_cnt == '0 && bus.release_req))
                  state <= WAIT_DISARM;
            end
            WAIT_DISARM: begin
               if (qual) begin
                  select_q <= '0;
                  state    <= IDLE;
                  done_q   <= 1'b1;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.select_line = select_q;
   assign bus.req_ready   = ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule
